// File: rtl/fft_frame_deserializer.sv
// Collects N_SAMPLES complex samples into a frame buffer, optionally in bit-reversed
// index order, and presents the whole frame in parallel. States: FILL = accepting, FULL = frame presented.
module fft_frame_deserializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_SAMPLES   = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [BIT_WIDTH-1:0]                 recv_msg_real,
  input  logic [BIT_WIDTH-1:0]                 recv_msg_imag,
  input  logic                                 recv_val,
  output logic                                 recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg_imag,
  output logic                                 send_val,
  input  logic                                 send_rdy
);

  localparam int CW = $clog2(N_SAMPLES);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]                          state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] re_q, im_q;
  logic [CW-1:0]                       wr_idx;
  logic                                wr_en;

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int b = 0; b < CW; b++) r[b] = v[CW-1-b];
    return r;
  endfunction

  // In FULL cnt_q is always 0, so the same index path lands sample 0 of the next frame at index 0.
  assign wr_idx   = (BIT_REVERSE != 0) ? bitrev(cnt_q) : cnt_q;
  assign recv_rdy = reset & ((state_q == ST_FILL) | send_rdy);
  assign wr_en    = recv_val & recv_rdy;

  assign send_val      = (state_q == ST_FULL);
  assign send_msg_real = re_q;
  assign send_msg_imag = im_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FILL: begin
        if (wr_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N_SAMPLES - 1)) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (send_rdy) begin
          state_d = ST_FILL;
          cnt_d   = wr_en ? CW'(1) : '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en) begin
        re_q[wr_idx] <= recv_msg_real;
        im_q[wr_idx] <= recv_msg_imag;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_deserializer.sv
// Drives natural-order and bit-reversed deserializers with shared stimulus and
// compares handshakes and full buffer contents against a frame-level reference model.
module tb_fft_frame_deserializer;

  localparam int W = 32;
  localparam int N = 8;
  localparam int L = 3;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] recv_msg_real, recv_msg_imag;
  logic recv_val, send_rdy;
  logic rdy0, rdy1, val0, val1;
  logic [N-1:0][W-1:0] re0, im0, re1, im1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: two frame images (natural, reversed), fill count and full flag
  logic [W-1:0] m_re [2][N];
  logic [W-1:0] m_im [2][N];
  int m_cnt;
  bit m_full;

  always #5 clk = ~clk;

  fft_frame_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N), .BIT_REVERSE(0)) dut_nat (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(rdy0),
    .send_msg_real(re0), .send_msg_imag(im0),
    .send_val(val0), .send_rdy(send_rdy)
  );

  fft_frame_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N), .BIT_REVERSE(1)) dut_rev (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(rdy1),
    .send_msg_real(re1), .send_msg_imag(im1),
    .send_val(val1), .send_rdy(send_rdy)
  );

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < L; b++) r = (r << 1) | ((k >> b) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        m_re[d][i] = '0;
        m_im[d][i] = '0;
      end
    m_cnt  = 0;
    m_full = 0;
  endtask

  task automatic check_frames();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("nat_real[%0d]", i), 64'(re0[i]), 64'(m_re[0][i]));
      chk($sformatf("nat_imag[%0d]", i), 64'(im0[i]), 64'(m_im[0][i]));
      chk($sformatf("rev_real[%0d]", i), 64'(re1[i]), 64'(m_re[1][i]));
      chk($sformatf("rev_imag[%0d]", i), 64'(im1[i]), 64'(m_im[1][i]));
    end
  endtask

  // Called at a negedge: drive, check, advance model, move to next negedge.
  task automatic step(input logic rv, input logic sr, input logic [W-1:0] re, input logic [W-1:0] im);
    logic exp_rdy;
    recv_val = rv; send_rdy = sr; recv_msg_real = re; recv_msg_imag = im;
    #1;
    exp_rdy = m_full ? sr : 1'b1;
    chk("nat_recv_rdy", 64'(rdy0), 64'(exp_rdy));
    chk("rev_recv_rdy", 64'(rdy1), 64'(exp_rdy));
    chk("nat_send_val", 64'(val0), 64'(m_full));
    chk("rev_send_val", 64'(val1), 64'(m_full));
    check_frames();
    if (m_full && sr) begin
      m_full = 0;
      m_cnt  = 0;
    end
    if (rv && exp_rdy) begin
      m_re[0][m_cnt] = re;       m_im[0][m_cnt] = im;
      m_re[1][rev(m_cnt)] = re;  m_im[1][rev(m_cnt)] = im;
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt  = 0;
        m_full = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b0; recv_val = 1'b1; send_rdy = 1'b1;
    recv_msg_real = 32'hDEAD_BEEF; recv_msg_imag = 32'hCAFE_F00D;
    model_clear();
    for (int c = 0; c < ncyc; c++) begin
      #1;
      chk("rst_nat_recv_rdy", 64'(rdy0), 64'(0));
      chk("rst_rev_recv_rdy", 64'(rdy1), 64'(0));
      chk("rst_nat_send_val", 64'(val0), 64'(0));
      chk("rst_rev_send_val", 64'(val1), 64'(0));
      check_frames();
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
    recv_msg_real = '0; recv_msg_imag = '0;
    model_clear();
    @(negedge clk);

    // reset held with recv_val high, then release
    do_reset(3);

    // natural / bit-reversed fill: real=k, imag=100+k
    for (int k = 0; k < N; k++) step(1'b1, 1'b1, W'(k), W'(100 + k));
    step(1'b0, 1'b1, '0, '0);

    // backpressure with 0x55 waiting, then same-edge acceptance into index 0
    for (int k = 0; k < N; k++) step(1'b1, 1'b1, $urandom, $urandom);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h55, 32'h55);
    step(1'b1, 1'b1, 32'h55, 32'h55);
    for (int k = 1; k < N; k++) step(1'b1, 1'b1, $urandom, $urandom);
    step(1'b0, 1'b1, '0, '0);

    // streaming: three back-to-back frames
    for (int k = 0; k < 3 * N; k++) step(1'b1, 1'b1, $urandom, $urandom);
    step(1'b0, 1'b1, '0, '0);

    // random valid gaps and backpressure
    for (int c = 0; c < 300; c++)
      step(1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    step(1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b1, '0, '0);

    // mid-frame reset discards partial frame
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, W'(50 + k), W'(60 + k));
    do_reset(1);
    for (int k = 0; k < N; k++) step(1'b1, 1'b1, W'(200 + k), W'(300 + k));
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
